// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready beat bus between pipeline stages
// The master drives valid/data/ctrl; the slave returns ready.
interface pipe_stage_skid_if #(
   parameter int DATA_W = 138,
   parameter int CTRL_W = 10
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, output data, output ctrl, input ready);
   modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with optional 2-entry skid and flush
// Holds up to two beats (main = head, skid = overflow); flush kills all held beats.
module pipe_stage_skid #(
   parameter int              DATA_W      = 138,
   parameter int              CTRL_W      = 10,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
   parameter bit              SKID_EN     = 1'b1,
   parameter int              DROP_W      = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   pipe_stage_skid_if.slave    in_bus,
   pipe_stage_skid_if.master   out_bus,
   output logic [1:0]          occupancy,
   output logic [DROP_W-1:0]   drop_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_data_q, skid_data_q;
   logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
   logic              in_fire, out_fire;
   logic              load_main_in, load_main_skid, load_skid;
   logic [1:0]        kill_n;
   logic [DROP_W:0]   drop_sum;
   logic [DROP_W-1:0] drop_d;

   assign out_bus.valid = (state_q != EMPTY);
   assign out_bus.data  = main_data_q;
   assign out_bus.ctrl  = out_bus.valid ? main_ctrl_q : CTRL_BUBBLE;

   assign in_fire  = in_bus.valid & in_bus.ready;
   assign out_fire = out_bus.valid & out_bus.ready;

   // With the skid, ready comes straight from a flop so out_ready never reaches in_ready.
   generate
      if (SKID_EN) begin : g_skid_ready
         logic ready_q;
         always_ff @(posedge clk) begin
            if (reset) ready_q <= 1'b1;
            else       ready_q <= (state_d != TWO);
         end
         assign in_bus.ready = ready_q;
      end else begin : g_comb_ready
         assign in_bus.ready = (state_q == EMPTY) | out_bus.ready;
      end
   endgenerate

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d      = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  load_main_in = 1'b1;
               end else if (in_fire && SKID_EN) begin
                  state_d   = TWO;
                  load_skid = 1'b1;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  state_d        = ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      case (state_q)
         ONE:     occupancy = 2'd1;
         TWO:     occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   // A beat leaving downstream on the flush edge is delivered, not dropped.
   assign kill_n   = occupancy - {1'b0, out_fire};
   assign drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'(kill_n);
   assign drop_d   = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= EMPTY;
         drop_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (flush) drop_cnt <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         if (load_main_in) begin
            main_data_q <= in_bus.data;
            main_ctrl_q <= in_bus.ctrl;
         end else if (load_main_skid) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
         end
         if (load_skid) begin
            skid_data_q <= in_bus.data;
            skid_ctrl_q <= in_bus.ctrl;
         end
      end
   end

endmodule
